// File: rtl/lcg_pkg.sv
// Shared types and default sizing for the linear-congruential word generator.
// Optional period detection is enabled by defining LCG_PERIOD_EN.
package lcg_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lcg_state_t;

  localparam int unsigned LCG_WIDTH   = 8;
  localparam int unsigned LCG_COUNT_W = 16;

endpackage

// File: rtl/lcg_step.sv
// One combinational LCG advance: next = x + (x << shift) + incr, truncated to WIDTH bits.
module lcg_step import lcg_pkg::*; #(
  parameter int unsigned WIDTH   = LCG_WIDTH,
  parameter int unsigned SHIFT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   x_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic [WIDTH-1:0]   incr_i,
  output logic [WIDTH-1:0]   next_o
);

  // Carries out of the top bit are discarded by the WIDTH-bit result.
  always_comb begin
    next_o = x_i + (x_i << shift_i) + incr_i;
  end

endmodule

// File: rtl/lcg_gen.sv
// Pseudorandom word generator with run/stop control, valid/ready output and saturating count.
// Define LCG_PERIOD_EN to build the period detector (period_hit_o / period_len_o).
module lcg_gen import lcg_pkg::*; #(
  parameter int unsigned WIDTH   = LCG_WIDTH,
  parameter int unsigned SHIFT_W = $clog2(WIDTH),
  parameter int unsigned COUNT_W = LCG_COUNT_W
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [WIDTH-1:0]   seed_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic [WIDTH-1:0]   incr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               period_hit_o,
  output logic [COUNT_W-1:0] period_len_o
);

  lcg_state_t         state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   step_seed, step_x;
  logic               accept;

  lcg_step #(
    .WIDTH   (WIDTH),
    .SHIFT_W (SHIFT_W)
  ) u_step_seed (
    .x_i     (seed_i),
    .shift_i (shift_i),
    .incr_i  (incr_i),
    .next_o  (step_seed)
  );

  lcg_step #(
    .WIDTH   (WIDTH),
    .SHIFT_W (SHIFT_W)
  ) u_step_x (
    .x_i     (x_q),
    .shift_i (shift_i),
    .incr_i  (incr_i),
    .next_o  (step_x)
  );

  assign out_valid_o = (state_q == RUN);
  assign out_data_o  = x_q;
  assign count_o     = count_q;
  assign accept      = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = RUN;
    end else if (stop_i) begin
      state_d = IDLE;
    end
  end

  // start overrides a coincident accept: the accepted word is dropped, not counted.
  always_comb begin
    x_d     = x_q;
    count_d = count_q;
    if (start_i) begin
      x_d     = step_seed;
      count_d = '0;
    end else if (accept) begin
      x_d = step_x;
      if (count_q != '1) begin
        count_d = count_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      x_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      count_q <= count_d;
    end
  end

`ifdef LCG_PERIOD_EN
  logic [WIDTH-1:0]   first_x_q, first_x_d;
  logic [COUNT_W-1:0] since_q, since_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic               hit_q, hit_d;
  logic [COUNT_W-1:0] since_inc;

  // Accepts since start or last hit, counting the one in flight.
  assign since_inc = (since_q != '1) ? since_q + COUNT_W'(1) : since_q;

  always_comb begin
    first_x_d = first_x_q;
    since_d   = since_q;
    len_d     = len_q;
    hit_d     = 1'b0;
    if (start_i) begin
      first_x_d = step_seed;
      since_d   = '0;
      len_d     = '0;
    end else if (accept) begin
      if (step_x == first_x_q) begin
        hit_d   = 1'b1;
        len_d   = since_inc;
        since_d = '0;
      end else begin
        since_d = since_inc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      first_x_q <= '0;
      since_q   <= '0;
      len_q     <= '0;
      hit_q     <= 1'b0;
    end else begin
      first_x_q <= first_x_d;
      since_q   <= since_d;
      len_q     <= len_d;
      hit_q     <= hit_d;
    end
  end

  assign period_hit_o = hit_q;
  assign period_len_o = len_q;
`else
  assign period_hit_o = 1'b0;
  assign period_len_o = '0;
`endif

endmodule

// File: tb/tb_lcg_gen.sv
// Self-checking bench for lcg_gen: directed plan items plus randomized traffic against a model.
module tb_lcg_gen;

  logic       clk;
  logic       reset_n;
  logic       start, stop, ready;
  logic [7:0] seed, incr;
  logic [2:0] shift;

  logic        valid, valid4;
  logic [7:0]  data, data4;
  logic [15:0] count, plen;
  logic [3:0]  count4, plen4;
  logic        phit, phit4;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_run;
  int unsigned m_x, m_first, m_count, m_count4, m_len, m_since;
  bit          m_hit;

  lcg_gen dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .start_i      (start),
    .stop_i       (stop),
    .seed_i       (seed),
    .shift_i      (shift),
    .incr_i       (incr),
    .out_valid_o  (valid),
    .out_ready_i  (ready),
    .out_data_o   (data),
    .count_o      (count),
    .period_hit_o (phit),
    .period_len_o (plen)
  );

  lcg_gen #(
    .COUNT_W (4)
  ) dut_c4 (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .start_i      (start),
    .stop_i       (stop),
    .seed_i       (seed),
    .shift_i      (shift),
    .incr_i       (incr),
    .out_valid_o  (valid4),
    .out_ready_i  (ready),
    .out_data_o   (data4),
    .count_o      (count4),
    .period_hit_o (phit4),
    .period_len_o (plen4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned model_step(input int unsigned x, input int unsigned sh,
                                             input int unsigned inc);
    longint unsigned v;
    v = longint'(x) + longint'(x) * (longint'(1) << sh) + longint'(inc);
    return int'(v % 256);
  endfunction

  task automatic model_reset();
    m_run = 0; m_x = 0; m_first = 0; m_count = 0; m_count4 = 0;
    m_len = 0; m_since = 0; m_hit = 0;
  endtask

  task automatic check_outputs();
    check_eq("valid", valid, m_run);
    check_eq("valid_c4", valid4, m_run);
    if (m_run) begin
      check_eq("data", data, m_x);
      check_eq("data_c4", data4, m_x);
    end
    check_eq("count", count, m_count);
    check_eq("count_c4", count4, m_count4);
    check_eq("period_hit", phit, m_hit);
    check_eq("period_len", plen, m_len);
    check_eq("period_hit_c4", phit4, m_hit);
  endtask

  // Advance one clock: model computes from the inputs the DUT sees at this edge.
  task automatic cycle();
    bit          acc;
    int unsigned nx;
    acc   = m_run && ready;
    m_hit = 0;
    if (start) begin
      m_x      = model_step(seed, shift, incr);
      m_first  = m_x;
      m_count  = 0;
      m_count4 = 0;
      m_len    = 0;
      m_since  = 0;
      m_run    = 1;
    end else begin
      if (acc) begin
        nx = model_step(m_x, shift, incr);
        if (m_count < 65535) m_count++;
        if (m_count4 < 15) m_count4++;
`ifdef LCG_PERIOD_EN
        m_since++;
        if (nx == m_first) begin
          m_hit   = 1;
          m_len   = m_since;
          m_since = 0;
        end
`endif
        m_x = nx;
      end
      if (stop) m_run = 0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_start(input logic [7:0] s, input logic [2:0] sh, input logic [7:0] inc);
    seed = s; shift = sh; incr = inc; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 0; stop = 0; ready = 0; seed = 0; shift = 0; incr = 0;
    model_reset();
    #2;
    check_outputs();
    #10 reset_n = 1'b1;
    repeat (2) cycle();

    // Basic sequence
    ready = 1'b1;
    do_start(8'h05, 3'd1, 8'h03);
    check_eq("seq0", data, 8'h12);
    check_eq("seq0_count", count, 0);
    cycle();
    check_eq("seq1", data, 8'h39);
    check_eq("seq1_count", count, 1);
    cycle();
    check_eq("seq2", data, 8'hAE);
    check_eq("seq2_count", count, 2);

    // Overflow wraps
    do_start(8'hFF, 3'd7, 8'h01);
    check_eq("overflow", data, 8'h80);

    // Backpressure
    ready = 1'b0;
    do_start(8'h05, 3'd1, 8'h03);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("bp_data", data, 8'h12);
      check_eq("bp_count", count, 0);
      check_eq("bp_valid", valid, 1);
    end
    ready = 1'b1;
    cycle();
    check_eq("bp_release", data, 8'h39);

    // Period detection on the fixed point 0
    do_start(8'h00, 3'd0, 8'h00);
    check_eq("per_data", data, 8'h00);
    check_eq("per_hit0", phit, 0);
    cycle();
`ifdef LCG_PERIOD_EN
    check_eq("per_hit1", phit, 1);
    check_eq("per_len1", plen, 1);
`else
    check_eq("per_hit_off", phit, 0);
    check_eq("per_len_off", plen, 0);
`endif

    // Counter saturation
    do_start(8'h05, 3'd1, 8'h03);
    repeat (20) cycle();
    check_eq("sat_c4", count4, 15);
    check_eq("sat_c16", count, 20);

    // start and stop together: start wins
    seed = 8'h05; shift = 3'd1; incr = 8'h03; start = 1'b1; stop = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0;
    check_eq("startstop_valid", valid, 1);
    check_eq("startstop_data", data, 8'h12);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check_eq("stop_valid", valid, 0);

    // Async reset mid-run
    do_start(8'h21, 3'd2, 8'h07);
    repeat (3) cycle();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_valid", valid, 0);
    check_eq("arst_data", data, 0);
    check_eq("arst_count", count, 0);
    check_outputs();
    #3 reset_n = 1'b1;
    repeat (3) begin
      cycle();
      check_eq("post_rst_idle", valid, 0);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      stop  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 19) == 0) begin
        seed  = 8'($urandom);
        shift = 3'($urandom);
        incr  = 8'($urandom);
        start = 1'b1;
      end
      cycle();
      start = 1'b0;
      stop  = 1'b0;
    end

    // Random restarts on short-period configurations exercise the period path
    for (int k = 0; k < 4; k++) begin
      ready = 1'b1;
      do_start(8'($urandom), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 1)));
      for (int i = 0; i < 40; i++) begin
        ready = ($urandom_range(0, 4) != 0);
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
